div_seq: RTL and testbench

//  Sequential signed 32-bit divider executing MIPS DIV on the controller's request.
//  The controller drives divControl and operands A/B; this block iterates and loads
//  hi (remainder) and lo (quotient). It raises div0 back to the controller's

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_seq.sv | 165 ++++++++++++++++
 tb/tb_div_seq.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the sequential divider. The multiplier unit imports
//   the same package, so the state encoding and the default width live here.
//
//   DIV_WIDTH   : default operand/result width. The iteration count equals it.
//   div_state_t : 2-bit FSM encoding: IDLE, RUN, FIX, ZERO.
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    ZERO = 2'd3
  } div_state_t;

endpackage : div_pkg

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
//   Sequential signed divider that executes MIPS DIV for the controller.
//   The divider uses magnitudes and a restoring algorithm: one quotient bit per
//   clock over WIDTH clocks, then one fix-up clock to apply the signs. Results
//   go to hi (remainder) and lo (quotient). The quotient truncates toward zero.
//   The remainder takes the dividend's sign.
//
// Ports
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous reset, active low
//   divControl in   1      start request, sampled only in IDLE
//   A          in   WIDTH  signed dividend, sampled with the start
//   B          in   WIDTH  signed divisor, sampled with the start
//   hi         out  WIDTH  remainder register
//   lo         out  WIDTH  quotient register
//   div0       out  1      one-cycle pulse: the divisor was zero
//   done       out  1      one-cycle pulse: hi/lo were updated this cycle
//   busy       out  1      high from the edge after the start until the
//                          done/div0 cycle ends
//   state      out  2      current FSM state, for observation
//
// Handshake
//   A request is accepted on a rising edge where state==IDLE and divControl==1.
//   A and B are captured on that same edge. Exactly one of done or div0 follows
//   later, as a single-cycle pulse. A request is ignored in RUN, FIX and ZERO.
//   Requests are not queued. If divControl stays high, the next operation
//   starts on the first IDLE edge after the pulse.
// -----------------------------------------------------------------------------
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             divControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0,
  output logic             done,
  output logic             busy,
  output div_state_t       state
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state_q;
  div_state_t       state_d;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             sign_a;
  logic             sign_q;

  logic             start;
  logic             last_step;
  logic [WIDTH-1:0] abs_a_in;
  logic [WIDTH-1:0] abs_b_in;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   trial;
  logic             ge;

  assign state = state_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    last_step = (counter == CW'(WIDTH - 1));
    case (state_q)
      IDLE: begin
        start = divControl;
        if (divControl) state_d = (B == '0) ? ZERO : RUN;
      end
      RUN:     if (last_step) state_d = FIX;
      FIX:     state_d = IDLE;
      ZERO:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand magnitudes and one restoring step.
  // The magnitude of the most negative value is exact when treated as unsigned.
  // A remainder below |B| <= 2^(WIDTH-1) still fits in WIDTH bits after the
  // shift. The trial subtract keeps one extra bit, so its borrow gives the
  // compare result.
  // ---------------------------------------------------------------------------
  always_comb begin
    abs_a_in = A[WIDTH-1] ? (~A + 1'b1) : A;
    abs_b_in = B[WIDTH-1] ? (~B + 1'b1) : B;
    rem_sh   = {rem[WIDTH-2:0], quo[WIDTH-1]};
    trial    = {1'b0, rem_sh} - {1'b0, abs_b};
    ge       = ~trial[WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi      <= '0;
      lo      <= '0;
      div0    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      counter <= '0;
      abs_b   <= '0;
      rem     <= '0;
      quo     <= '0;
      sign_a  <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      case (state_q)
        IDLE: begin
          // During the done cycle the FSM is already in IDLE. Busy drops here
          // unless a new request starts on this same edge.
          busy <= start;
          if (start) begin
            abs_b   <= abs_b_in;
            quo     <= abs_a_in;
            rem     <= '0;
            sign_a  <= A[WIDTH-1];
            sign_q  <= A[WIDTH-1] ^ B[WIDTH-1];
            counter <= '0;
            div0    <= (B == '0);
          end
        end
        RUN: begin
          rem     <= ge ? trial[WIDTH-1:0] : rem_sh;
          quo     <= {quo[WIDTH-2:0], ge};
          counter <= counter + CW'(1);
        end
        FIX: begin
          lo   <= sign_q ? (~quo + 1'b1) : quo;
          hi   <= sign_a ? (~rem + 1'b1) : rem;
          done <= 1'b1;
        end
        ZERO: begin
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule : div_seq

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq
//   Directed-vector bench for div_seq. Each scenario task drives its own
//   stimulus and checks the results inline against hand-computed values.
// -----------------------------------------------------------------------------
module tb_div_seq;
  import div_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         divControl;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div0;
  logic         done;
  logic         busy;
  div_state_t   state;

  int vec_count;
  int err_count;

  div_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .divControl (divControl),
    .A          (A),
    .B          (B),
    .hi         (hi),
    .lo         (lo),
    .div0       (div0),
    .done       (done),
    .busy       (busy),
    .state      (state)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------

  // Wait (bounded) for done or div0, sampling on falling edges.
  // lat counts the rising edges from E0 up to the edge that raised the pulse.
  task automatic wait_pulse(inout int lat, output logic got_done, output logic got_div0);
    got_done = done;
    got_div0 = div0;
    while (!got_done && !got_div0 && lat < 80) begin
      @(negedge clk);
      lat++;
      got_done = done;
      got_div0 = div0;
    end
  endtask

  // Issue a one-cycle request and wait for the result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic got_done, output logic got_div0);
    @(negedge clk);
    A = a;
    B = b;
    divControl = 1'b1;
    @(negedge clk);          // E0 has passed
    divControl = 1'b0;
    lat = 1;
    wait_pulse(lat, got_done, got_div0);
  endtask

  // Run one operation and check its latency, result and pulse shape.
  task automatic check_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
    int   lat;
    logic gd, gz;
    run_op(a, b, lat, gd, gz);
    vec_count++;
    if (lat !== 34 || gd !== 1'b1 || gz !== 1'b0) begin
      err_count++;
      $display("FAIL %s latency/pulse: lat=%0d done=%b div0=%b, required lat=34 done=1 div0=0",
               name, lat, gd, gz);
    end
    vec_count++;
    if (lo !== exp_lo) begin
      err_count++;
      $display("FAIL %s lo: got %h required %h", name, lo, exp_lo);
    end
    vec_count++;
    if (hi !== exp_hi) begin
      err_count++;
      $display("FAIL %s hi: got %h required %h", name, hi, exp_hi);
    end
    vec_count++;
    if (busy !== 1'b1) begin
      err_count++;
      $display("FAIL %s busy_in_done_cycle: got %b required 1", name, busy);
    end
    @(negedge clk);
    vec_count++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      err_count++;
      $display("FAIL %s after_done: done=%b busy=%b required 0 0", name, done, busy);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenario tasks
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    divControl = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    vec_count++;
    if (hi !== '0 || lo !== '0 || div0 !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || state !== IDLE) begin
      err_count++;
      $display("FAIL reset_state: hi=%h lo=%h div0=%b done=%b busy=%b state=%0d, required all zero/IDLE",
               hi, lo, div0, done, busy, state);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    check_div("pos_pos", 32'd100, 32'd7, 32'd14, 32'd2);
  endtask

  task automatic test_signs();
    check_div("neg_pos", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    check_div("pos_neg", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
    check_div("neg_neg", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
    check_div("small_by_big", 32'd3, 32'd10, 32'd0, 32'd3);
  endtask

  task automatic test_div_zero();
    int   lat;
    logic gd, gz;
    // 1105 = 34*32 + 17 preloads lo=0x22, hi=0x11
    check_div("preload", 32'd1105, 32'd32, 32'h22, 32'h11);
    run_op(32'd5, 32'd0, lat, gd, gz);
    vec_count++;
    if (lat !== 1 || gz !== 1'b1 || gd !== 1'b0 || busy !== 1'b1 || state !== ZERO) begin
      err_count++;
      $display("FAIL div0_pulse: lat=%0d div0=%b done=%b busy=%b state=%0d, required 1 1 0 1 ZERO",
               lat, gz, gd, busy, state);
    end
    vec_count++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      err_count++;
      $display("FAIL div0_hold: hi=%h lo=%h required 00000011 00000022", hi, lo);
    end
    // No done may follow, and div0 must last one cycle only.
    gd = 1'b0;
    gz = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) gd = 1'b1;
      if (div0) gz = 1'b1;
    end
    vec_count++;
    if (gd !== 1'b0 || gz !== 1'b0 || busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
      err_count++;
      $display("FAIL div0_after: done_seen=%b div0_seen=%b busy=%b hi=%h lo=%h, required 0 0 0 11 22",
               gd, gz, busy, hi, lo);
    end
  endtask

  task automatic test_overflow();
    check_div("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    check_div("min_by_one", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'h0);
  endtask

  task automatic test_ignore_busy();
    int   lat;
    logic gd, gz;
    @(negedge clk);
    A = 32'd1000;
    B = 32'd7;
    divControl = 1'b1;
    @(negedge clk);
    divControl = 1'b0;
    lat = 1;
    repeat (10) begin
      @(negedge clk);
      lat++;
    end
    // Now just after RUN step 10: request a different op for one cycle.
    A = 32'd9;
    B = 32'd3;
    divControl = 1'b1;
    @(negedge clk);
    lat++;
    divControl = 1'b0;
    wait_pulse(lat, gd, gz);
    vec_count++;
    if (lat !== 34 || gd !== 1'b1 || lo !== 32'd142 || hi !== 32'd6) begin
      err_count++;
      $display("FAIL ignore_busy: lat=%0d done=%b lo=%0d hi=%0d, required 34 1 142 6",
               lat, gd, lo, hi);
    end
    repeat (3) @(negedge clk);
    vec_count++;
    if (busy !== 1'b0 || state !== IDLE) begin
      err_count++;
      $display("FAIL ignore_no_queue: busy=%b state=%0d required 0 IDLE", busy, state);
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic gd, gz;
    @(negedge clk);
    A = 32'd20;
    B = 32'd6;
    divControl = 1'b1;       // held high across both operations
    @(negedge clk);
    lat = 1;
    wait_pulse(lat, gd, gz);
    vec_count++;
    if (lat !== 34 || gd !== 1'b1 || lo !== 32'd3 || hi !== 32'd2) begin
      err_count++;
      $display("FAIL b2b_first: lat=%0d done=%b lo=%h hi=%h, required 34 1 3 2", lat, gd, lo, hi);
    end
    // Done cycle: the next edge is in IDLE and starts the second operation.
    A = 32'hFFFF_FFEC;       // -20
    B = 32'd6;
    @(negedge clk);
    divControl = 1'b0;
    vec_count++;
    if (busy !== 1'b1 || state !== RUN || done !== 1'b0) begin
      err_count++;
      $display("FAIL b2b_restart: busy=%b state=%0d done=%b, required 1 RUN 0", busy, state, done);
    end
    lat = 1;
    wait_pulse(lat, gd, gz);
    vec_count++;
    if (lat !== 34 || gd !== 1'b1 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFE) begin
      err_count++;
      $display("FAIL b2b_second: lat=%0d done=%b lo=%h hi=%h, required 34 1 fffffffd fffffffe",
               lat, gd, lo, hi);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    A = 32'd1000;
    B = 32'd3;
    divControl = 1'b1;
    @(negedge clk);
    divControl = 1'b0;
    repeat (16) @(negedge clk);
    vec_count++;
    if (busy !== 1'b1 || state !== RUN || lo === 32'd0) begin
      err_count++;
      $display("FAIL pre_reset: busy=%b state=%0d lo=%h, required 1 RUN nonzero", busy, state, lo);
    end
    #1 reset = 1'b0;
    #1;
    vec_count++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || state !== IDLE || done !== 1'b0 || div0 !== 1'b0) begin
      err_count++;
      $display("FAIL async_reset: hi=%h lo=%h busy=%b state=%0d done=%b div0=%b, required zeros IDLE",
               hi, lo, busy, state, done, div0);
    end
    @(negedge clk);
    reset = 1'b1;
    check_div("after_reset", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    vec_count = 0;
    err_count = 0;
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule : tb_div_seq
